// File: rtl/alu.sv
// Registered 32-bit integer ALU with an RV32I operation decoder (execute stage).
// The decoder turns opcode/funct3/funct7[5] into a 4-bit ALUop. The datapath applies
// that operation to A/B, and the result is captured into Out on every rising edge.
//
// Optional feature macro: ALU_ILLEGAL_EN adds the registered Illegal output.
//
// Ports:
//   Clock           - rising-edge clock
//   Reset_n         - asynchronous active-low reset (clears Out/Illegal)
//   opcode[6:0]     - instruction opcode
//   funct[2:0]      - instruction funct3
//   add_rshift_type - instruction bit 30 (funct7[5])
//   A[31:0]         - operand A (rs1 or PC)
//   B[31:0]         - operand B (rs2 or immediate)
//   ALUop[3:0]      - combinational decoded operation
//   Out[31:0]       - registered result
//   Illegal         - registered undecodable-operation flag (ALU_ILLEGAL_EN only)
module alu (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        add_rshift_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [3:0]  ALUop,
`ifdef ALU_ILLEGAL_EN
  output logic        Illegal,
`endif
  output logic [31:0] Out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SH_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
  localparam logic [OP_W-1:0] OP_CPB  = 4'd10;
  localparam logic [OP_W-1:0] OP_XXX  = 4'd15;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  logic [DATA_W-1:0] result;
  logic [SH_W-1:0]   shamt;

  // Operation decoder; ADDI has no SUB form, so bit 30 only matters for R-type funct3=000.
  always_comb begin
    ALUop = OP_XXX;
    unique case (opcode)
      OPC_LUI: ALUop = OP_CPB;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: ALUop = OP_ADD;
      OPC_RTYPE, OPC_ITYPE: begin
        unique case (funct)
          3'b000: ALUop = (opcode == OPC_RTYPE && add_rshift_type) ? OP_SUB : OP_ADD;
          3'b001: ALUop = OP_SLL;
          3'b010: ALUop = OP_SLT;
          3'b011: ALUop = OP_SLTU;
          3'b100: ALUop = OP_XOR;
          3'b101: ALUop = add_rshift_type ? OP_SRA : OP_SRL;
          3'b110: ALUop = OP_OR;
          3'b111: ALUop = OP_AND;
          default: ALUop = OP_XXX;
        endcase
      end
      default: ALUop = OP_XXX;
    endcase
  end

  assign shamt = B[SH_W-1:0];

  // Datapath; unknown operations produce zero.
  always_comb begin
    result = '0;
    unique case (ALUop)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_SLT:  result = DATA_W'($signed(A) < $signed(B));
      OP_SLTU: result = DATA_W'(A < B);
      OP_SLL:  result = A << shamt;
      OP_SRL:  result = A >> shamt;
      OP_SRA:  result = DATA_W'($signed(A) >>> shamt);
      OP_CPB:  result = B;
      default: result = '0;
    endcase
  end

  // Result register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Out <= '0;
    end else begin
      Out <= result;
    end
  end

`ifdef ALU_ILLEGAL_EN
  // Illegal flag travels with the result it describes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Illegal <= 1'b0;
    end else begin
      Illegal <= (ALUop == OP_XXX);
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized stimulus against a
// behavioural reference model of the RV32I decode and arithmetic rules.
module tb_alu;

  logic        Clock;
  logic        Reset_n;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
`ifdef ALU_ILLEGAL_EN
  logic        Illegal;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;

  alu dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .opcode(opcode),
    .funct(funct),
    .add_rshift_type(add_rshift_type),
    .A(A),
    .B(B),
    .ALUop(ALUop),
`ifdef ALU_ILLEGAL_EN
    .Illegal(Illegal),
`endif
    .Out(Out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the instruction-class rules.
  function automatic int model_op(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    if (opc == LUI) return 10;
    if (opc inside {AUIPC, JAL, JALR, BRANCH, LOAD, STORE}) return 0;
    if (opc == RTYPE || opc == ITYPE) begin
      case (f3)
        3'd0: return (opc == RTYPE && b30) ? 1 : 0;
        3'd1: return 7;
        3'd2: return 5;
        3'd3: return 6;
        3'd4: return 4;
        3'd5: return b30 ? 9 : 8;
        3'd6: return 3;
        default: return 2;
      endcase
    end
    return 15;
  endfunction

  // Reference arithmetic.
  function automatic logic [31:0] model_res(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    logic [31:0] ones;
    sh = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    fill = a[31] ? ~(ones >> sh) : 32'h0;
    case (op)
      0:  return a + b;
      1:  return a + (~b + 32'd1);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      6:  return {31'b0, a < b};
      7:  return a << sh;
      8:  return a >> sh;
      9:  return (a >> sh) | fill;
      10: return b;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one operation at the falling edge, check decode, then the captured result.
  task automatic apply(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic b30, input logic [31:0] a, input logic [31:0] b);
    int op;
    @(negedge Clock);
    opcode = opc; funct = f3; add_rshift_type = b30; A = a; B = b;
    op = model_op(opc, f3, b30);
    #1;
    check({tag, ".op"}, {28'b0, ALUop}, 32'(op));
    @(posedge Clock);
    #1;
    check({tag, ".out"}, Out, model_res(op, a, b));
`ifdef ALU_ILLEGAL_EN
    check({tag, ".ill"}, {31'b0, Illegal}, {31'b0, op == 15});
`endif
  endtask

  initial begin
    logic [6:0] legal [9];
    logic [6:0] opc;
    legal = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, RTYPE, ITYPE};

    // Reset held with an ADD that would wrap.
    Reset_n = 1'b0;
    opcode = LOAD; funct = 3'd0; add_rshift_type = 1'b0;
    A = 32'hFFFF_FFFF; B = 32'h1;
    #1;
    check("rst.async", Out, 32'h0);
    repeat (3) begin
      @(posedge Clock); #1;
      check("rst.hold", Out, 32'h0);
`ifdef ALU_ILLEGAL_EN
      check("rst.ill", {31'b0, Illegal}, 32'h0);
`endif
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    check("rst.wrap", Out, 32'h0);

    // LUI and the ADD-class opcodes.
    apply("lui", LUI, 3'($urandom), 1'($urandom), 32'h8000_1234, 32'hFFFF_8ABC);
    check("lui.val", Out, 32'hFFFF_8ABC);
    apply("auipc", AUIPC, 3'($urandom), 1'($urandom), 32'h8000_1234, 32'hFFFF_8ABC);
    check("auipc.val", Out, 32'h7FFF_9CF0);
    apply("load", LOAD, 3'($urandom), 1'($urandom), 32'h8000_1234, 32'hFFFF_8ABC);
    check("load.val", Out, 32'h7FFF_9CF0);
    apply("store", STORE, 3'($urandom), 1'($urandom), 32'h8000_1234, 32'hFFFF_8ABC);
    check("store.val", Out, 32'h7FFF_9CF0);
    apply("branch", BRANCH, 3'($urandom), 1'($urandom), 32'h8000_1234, 32'hFFFF_8ABC);
    check("branch.val", Out, 32'h7FFF_9CF0);

    // ADD/SUB selection.
    apply("radd", RTYPE, 3'd0, 1'b0, 32'd10, 32'd15);
    check("radd.val", Out, 32'd25);
    apply("rsub", RTYPE, 3'd0, 1'b1, 32'd10, 32'd15);
    check("rsub.val", Out, 32'hFFFF_FFFB);
    apply("iadd", ITYPE, 3'd0, 1'b1, 32'd10, 32'd15);
    check("iadd.val", Out, 32'd25);

    // Shifts use B[4:0] only.
    apply("sra", RTYPE, 3'd5, 1'b1, 32'hFFFF_F000, 32'h0000_0024);
    check("sra.val", Out, 32'hFFFF_FF00);
    apply("srl", RTYPE, 3'd5, 1'b0, 32'hFFFF_F000, 32'h0000_0024);
    check("srl.val", Out, 32'h0FFF_FF00);

    // Signed vs unsigned compare.
    apply("slt", RTYPE, 3'd2, 1'b0, 32'h8000_0000, 32'h1);
    check("slt.val", Out, 32'h1);
    apply("sltu", ITYPE, 3'd3, 1'b0, 32'h8000_0000, 32'h1);
    check("sltu.val", Out, 32'h0);

    // Undefined opcode.
    apply("undef", 7'b1111111, 3'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    check("undef.op", {28'b0, ALUop}, 32'd15);
    check("undef.val", Out, 32'h0);
`ifdef ALU_ILLEGAL_EN
    check("undef.ill", {31'b0, Illegal}, 32'h1);
`endif

    // Mid-stream reset discards the captured result.
    apply("pre", RTYPE, 3'd6, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst.async", Out, 32'h0);
    @(posedge Clock); #1;
    check("midrst.hold", Out, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Randomized operations, mostly legal opcodes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
      else opc = legal[$urandom_range(0, 8)];
      apply("rnd", opc, 3'($urandom), 1'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer ALU with an integrated RV32I operation decoder, used in the execute stage of the RISC-V core. The decoder maps opcode, funct3 and the funct7[5] bit (`add_rshift_type`) to an internal 4-bit `ALUop`. The datapath applies that operation to operands `A`/`B`. Operand muxing (PC vs. rs1, immediate vs. rs2) is done upstream; this block only computes.

## Interface
- No parameters; width is fixed at 32 bits.
- `Clock` — input, 1 bit: rising-edge clock.
- `Reset_n` — input, 1 bit: asynchronous, active-low reset.
- `opcode` — input, 7 bits: instruction opcode [6:0].
- `funct` — input, 3 bits: instruction funct3.
- `add_rshift_type` — input, 1 bit: instruction bit 30 (funct7[5]).
- `A` — input, 32 bits: operand A (rs1 or PC).
- `B` — input, 32 bits: operand B (rs2 or immediate; already sign-extended or shifted by the producer).
- `ALUop` — output, 4 bits: combinational decoder output.
- `Out` — output, 32 bits: registered result.
- `Illegal` — output, 1 bit: registered undecodable-operation flag; present only with `ALU_ILLEGAL_EN`.

## Operation
- ALUop encoding:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, COPY_B=10.
  - XXX=15 means illegal or unknown.
- Opcode decode:
  - LUI (0110111) → COPY_B.
  - AUIPC (0010111), JAL (1101111), JALR (1100111), BRANCH (1100011), LOAD (0000011), STORE (0100011) → ADD.
  - For all of these, `funct` and `add_rshift_type` are ignored.
- ARI_RTYPE (0110011), by funct3:
  - 000: ADD if `add_rshift_type`=0, SUB if 1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL if `add_rshift_type`=0, SRA if 1.
  - 110: OR. 111: AND.
- ARI_ITYPE (0010011): same table as ARI_RTYPE, except funct3=000 is always ADD (ADDI has no SUB form; `add_rshift_type` is ignored).
- Any other opcode → XXX.
- Datapath rules:
  - ADD/SUB are modulo 2^32; no flags.
  - AND/OR/XOR are bitwise.
  - SLT: 1 if $signed(A) < $signed(B), else 0. SLTU: the unsigned comparison. Both return 32'h0000_0001 or 32'h0000_0000.
  - Shifts use B[4:0] only; B[31:5] is ignored.
  - SRA replicates A[31]; SLL and SRL zero-fill.
  - COPY_B: Out = B.
  - XXX: result is 32'h0.

## Timing
- `ALUop` is purely combinational from `opcode`/`funct`/`add_rshift_type`.
- `Out` is registered: the value computed from the inputs present at rising edge N appears after edge N and holds until edge N+1. Latency is one cycle, throughput one operation per cycle.
- No handshake and no stall input; the register updates every cycle.
- Reset: when `Reset_n` is low, `Out` = 32'h0 and `Illegal` = 0 immediately (asynchronous), and stay so while reset is asserted.
- On reset release, the first capture occurs at the next rising edge. Reset asserted mid-stream discards the in-flight result.

## Configuration
- `ALU_ILLEGAL_EN` defined:
  - `Illegal` port exists.
  - `Illegal` is registered alongside `Out` and equals 1 in the cycle after an XXX decode.
- `ALU_ILLEGAL_EN` undefined:
  - No `Illegal` port.
  - XXX still yields `Out` = 0.

## Test plan
- Reset: hold `Reset_n`=0 with A=32'hFFFF_FFFF, B=1 and ADD selected → `Out`=0 throughout; release, one edge later → `Out`=32'h0000_0000 (wrap-around).
- LUI with random `funct`/`add_rshift_type`, A=32'h8000_1234, B=32'hFFFF_8ABC → `ALUop`=10, next cycle `Out`=32'hFFFF_8ABC. The same operands with AUIPC/LOAD/STORE/BRANCH → `Out`=32'h7FFF_9CF0.
- R-type funct3=000, A=10, B=15: `add_rshift_type`=0 → `Out`=25; `add_rshift_type`=1 → `Out`=32'hFFFF_FFFB.
- I-type funct3=000 with `add_rshift_type`=1, A=10, B=15 → `Out`=25 (no SUB).
- SRA, A=32'hFFFF_F000, B=32'h0000_0024 (shamt 4) → `Out`=32'hFFFF_FF00. SRL with the same operands → 32'h0FFF_FF00.
- SLT/SLTU with A=32'h8000_0000, B=1: SLT → 1, SLTU → 0. An undefined opcode 1111111 → `ALUop`=15, `Out`=0, and `Illegal`=1 when `ALU_ILLEGAL_EN` is defined.
